// File: rtl/pwr_step_sequencer.sv
// Load-step sequencer: ramps a thermometer-coded enable bus from 0 to NUM_MODULES
// in fixed steps, holding each level for a programmable dwell so power can be sampled.
module pwr_step_sequencer #(
  parameter int NUM_MODULES = 32,
  parameter int DWELL_W     = 32
) (
  input  logic                   clk100m,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [DWELL_W-1:0]     dwell_cycles,
  input  logic [5:0]             step_size,
  output logic [NUM_MODULES-1:0] pwr_en_out,
  output logic [5:0]             level,
  output logic                   level_strobe,
  output logic                   busy,
  output logic                   done
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [5:0] LP_LAST = 6'(NUM_MODULES);

  logic [0:0]             r_state;
  logic [DWELL_W-1:0]     r_dwell;
  logic [5:0]             r_step;
  logic [DWELL_W-1:0]     r_cnt;
  logic [5:0]             r_level;
  logic [NUM_MODULES-1:0] r_en;
  logic                   r_strobe;
  logic                   r_busy;
  logic                   r_done;

  logic [6:0]             w_sum;
  logic [5:0]             w_next_level;
  logic                   w_dwell_end;
  logic                   w_final;

  function automatic logic [NUM_MODULES-1:0] f_therm(input logic [5:0] lvl);
    logic [NUM_MODULES-1:0] t;
    for (int j = 0; j < NUM_MODULES; j++) begin
      t[j] = (j < int'(lvl));
    end
    return t;
  endfunction

  // Level+step is formed one bit wider so the clamp sees the true sum.
  assign w_sum        = {1'b0, r_level} + {1'b0, r_step};
  assign w_next_level = (w_sum >= {1'b0, LP_LAST}) ? LP_LAST : w_sum[5:0];
  assign w_dwell_end  = (r_cnt == r_dwell);
  assign w_final      = (r_level == LP_LAST);

  always_ff @(posedge clk100m) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_dwell  <= '0;
      r_step   <= '0;
      r_cnt    <= '0;
      r_level  <= '0;
      r_en     <= '0;
      r_strobe <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && !abort) begin
            r_state  <= ST_RUN;
            r_dwell  <= (dwell_cycles == '0) ? DWELL_W'(1) : dwell_cycles;
            r_step   <= (step_size == 6'd0) ? 6'd1 : step_size;
            r_cnt    <= DWELL_W'(1);
            r_level  <= '0;
            r_en     <= '0;
            r_strobe <= 1'b1;
            r_busy   <= 1'b1;
          end
        end
        ST_RUN: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_level <= '0;
            r_en    <= '0;
            r_busy  <= 1'b0;
          end else if (w_dwell_end) begin
            if (w_final) begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
              r_level <= '0;
              r_en    <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              // Terminal compare then reload keeps the counter from ever wrapping.
              r_cnt    <= DWELL_W'(1);
              r_level  <= w_next_level;
              r_en     <= f_therm(w_next_level);
              r_strobe <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + DWELL_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign pwr_en_out   = r_en;
  assign level        = r_level;
  assign level_strobe = r_strobe;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

// File: tb/tb_pwr_step_sequencer.sv
// Bench for pwr_step_sequencer: directed scenarios plus random traffic, compared each
// cycle against a sweep model built from the level list and dwell arithmetic.
module tb_pwr_step_sequencer;
  localparam int N  = 32;
  localparam int DW = 32;

  logic          clk100m = 1'b0;
  logic          rst, start, abort;
  logic [DW-1:0] dwell_cycles;
  logic [5:0]    step_size;
  logic [N-1:0]  pwr_en_out;
  logic [5:0]    level;
  logic          level_strobe, busy, done;

  always #5 clk100m = ~clk100m;

  pwr_step_sequencer #(.NUM_MODULES(N), .DWELL_W(DW)) dut (
    .clk100m(clk100m), .rst(rst), .start(start), .abort(abort),
    .dwell_cycles(dwell_cycles), .step_size(step_size),
    .pwr_en_out(pwr_en_out), .level(level), .level_strobe(level_strobe),
    .busy(busy), .done(done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Sweep model: list of levels, each held m_d cycles; m_k counts cycles since start.
  bit  m_active = 0;
  bit  m_done   = 0;
  int  m_k      = 0;
  int  m_d      = 1;
  int  m_lv[$];

  task automatic model_edge();
    m_done = 0;
    if (rst) begin
      m_active = 0;
    end else if (m_active) begin
      if (abort) m_active = 0;
      else begin
        m_k++;
        if ((m_k - 1) / m_d >= m_lv.size()) begin
          m_active = 0;
          m_done   = 1;
        end
      end
    end else if (start && !abort) begin
      int s, l;
      s    = (step_size == 0) ? 1 : int'(step_size);
      m_d  = (dwell_cycles == 0) ? 1 : int'(dwell_cycles);
      m_lv.delete();
      l = 0;
      m_lv.push_back(l);
      while (l < N) begin
        l = (l + s > N) ? N : l + s;
        m_lv.push_back(l);
      end
      m_active = 1;
      m_k      = 1;
    end
  endtask

  task automatic step();
    int           el, idx;
    bit           es, eb;
    logic [63:0]  een;
    @(posedge clk100m);
    model_edge();
    @(negedge clk100m);
    el = 0; es = 0; eb = 0;
    if (m_active) begin
      idx = (m_k - 1) / m_d;
      el  = m_lv[idx];
      es  = ((m_k - 1) % m_d) == 0;
      eb  = 1;
    end
    een = (el == 0) ? 64'd0 : ((64'd1 << el) - 64'd1);
    chk("level",  64'(level), 64'(el));
    chk("pwr_en", 64'(pwr_en_out), een);
    chk("strobe", 64'(level_strobe), 64'(es));
    chk("busy",   64'(busy), 64'(eb));
    chk("done",   64'(done), 64'(m_done));
  endtask

  task automatic drive(input bit s, input bit a, input int d, input int sz);
    start        = s;
    abort        = a;
    dwell_cycles = DW'(d);
    step_size    = 6'(sz);
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) begin
      start = 0; abort = 0;
      step();
    end
  endtask

  initial begin
    rst = 1; drive(0, 0, 0, 0);
    step();
    step();
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 0;
    run_idle(2);

    // Basic ramp S=8 D=4 with spot checks against the expected timeline.
    drive(1, 0, 4, 8);
    for (int c = 1; c <= 22; c++) begin
      step();
      start = 0;
      if (c == 5)  chk("basic_c5",  64'(pwr_en_out), 64'h0000_00FF);
      if (c == 17) chk("basic_c17", 64'(pwr_en_out), 64'hFFFF_FFFF);
      if (c == 21) chk("basic_done", 64'(done), 64'd1);
    end

    // Clamp S=5 D=2, then degenerate S=0 D=0.
    drive(1, 0, 2, 5);
    for (int c = 1; c <= 19; c++) begin
      step(); start = 0;
      if (c == 15) chk("clamp_32", 64'(level), 64'd32);
      if (c == 17) chk("clamp_done", 64'(done), 64'd1);
    end
    drive(1, 0, 0, 0);
    for (int c = 1; c <= 36; c++) begin
      step(); start = 0;
      if (c == 34) chk("degen_done", 64'(done), 64'd1);
    end

    // Abort at cycle 10, then a full sweep.
    drive(1, 0, 4, 8);
    for (int c = 1; c <= 12; c++) begin
      step(); start = 0; abort = (c == 10);
      if (c == 11) chk("abort_busy", 64'(busy), 64'd0);
    end
    abort = 0;
    drive(1, 0, 4, 8);
    for (int c = 1; c <= 22; c++) begin step(); start = 0; end

    // Start while busy (different config) must not disturb the sweep.
    drive(1, 0, 4, 8);
    for (int c = 1; c <= 22; c++) begin
      step();
      if (c == 3) drive(1, 0, 1, 1); else drive(0, 0, 9, 3);
    end

    // Abort on the final dwell cycle: no done.
    drive(1, 0, 4, 8);
    for (int c = 1; c <= 22; c++) begin
      step(); start = 0; abort = (c == 20);
    end
    abort = 0;

    // Start on the done cycle chains a new sweep.
    drive(1, 0, 4, 8);
    for (int c = 1; c <= 21; c++) begin
      step();
      if (c == 21) drive(1, 0, 3, 16); else start = 0;
    end
    step(); start = 0;
    chk("chain_busy", 64'(busy), 64'd1);
    run_idle(14);

    // Reset at cycle 7, then config churn mid-sweep.
    drive(1, 0, 4, 8);
    for (int c = 1; c <= 9; c++) begin
      step(); start = 0; rst = (c == 7);
      if (c == 8) chk("rst_mid", 64'(pwr_en_out), 64'd0);
    end
    rst = 0;
    drive(1, 0, 3, 7);
    for (int c = 1; c <= 20; c++) begin
      step(); drive(0, 0, $urandom_range(0, 9), $urandom_range(0, 63));
    end
    run_idle(5);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom_range(0, 9) == 0), ($urandom_range(0, 59) == 0),
            $urandom_range(0, 5), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63)
                                                             : $urandom_range(0, 12));
      rst = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 0;
    run_idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pwr_step_sequencer.md
Name: pwr_step_sequencer

Overview:
Schedules the per-module `pwr_en_in` enables of the power-estimation harness. It ramps the number of active user modules from 0 to NUM_MODULES in configurable steps. Each level is held for a configurable dwell time so external power measurement can sample a stable load. It sits between the host/config logic and the `user` block's `pwr_en_in` bus, and emits markers so captured power traces can be aligned with the load level.

Parameters:
NUM_MODULES, 32, number of enable lines driven (1..63)
DWELL_W, 32, width of dwell cycle count

Ports:
clk100m  in  1  system clock, 100 MHz
rst  in  1  synchronous reset, active-high
start  in  1  single-cycle request to begin a sweep
abort  in  1  single-cycle request to cancel a sweep
dwell_cycles  in  DWELL_W  cycles each level is held; sampled at start
step_size  in  6  modules added per level; sampled at start
pwr_en_out  out  NUM_MODULES  thermometer-coded enables, drives pwr_en_in
level  out  6  number of modules currently enabled
level_strobe  out  1  pulses on the first cycle of each level
busy  out  1  high while a sweep is in progress
done  out  1  one-cycle pulse when a sweep completes normally

Behaviour:
- Interface: one clock, `clk100m`. Reset `rst` is synchronous and active-high. All outputs are registered.
- Reset values: pwr_en_out=0, level=0, level_strobe=0, busy=0, done=0. State is IDLE, and the dwell counter and latched config are cleared.
- States:
  - IDLE -> RUN on start.
  - RUN -> IDLE when the final level's dwell expires (done path).
  - RUN -> IDLE on abort (abort path).
- Config latch: on an accepted start, latch dwell_cycles and step_size.
  - step_size=0 is treated as 1; dwell_cycles=0 is treated as 1.
  - Inputs changing mid-sweep have no effect.
- Start timing: start sampled high in IDLE at edge t gives the following on cycle t+1:
  - busy=1, level=0, pwr_en_out=0, level_strobe=1.
  - This is the baseline level.
- Level hold and advance:
  - Each level is held exactly D cycles (D = effective dwell).
  - On the D-th cycle the next edge sets level = min(level+S, NUM_MODULES), updates pwr_en_out, and pulses level_strobe for 1 cycle.
- Level sequence: 0, S, 2S, ..., clamped to NUM_MODULES. The final level is always NUM_MODULES, and a clamped level is not repeated.
- Enable encoding: pwr_en_out[j] = (j < level), a thermometer code from bit 0.
- Completion: after the final level's D cycles, the next cycle has:
  - pwr_en_out=0, level=0, busy=0, done=1 for exactly 1 cycle.
  - State returns to IDLE.
- Abort:
  - abort in RUN: the next cycle has pwr_en_out=0, level=0, busy=0, and no done pulse.
  - abort in IDLE: ignored.
  - abort and final-dwell expiry on the same cycle: abort wins, no done.
  - abort and start on the same cycle in IDLE: abort wins, no sweep starts.
- start while busy: ignored; it neither restarts the sweep nor changes the config.
- start on the same cycle done is asserted: accepted (state is already IDLE).
- Reset mid-sweep: outputs return to reset values on the next cycle, with no done pulse.
- Dwell counter:
  - Counts 1..D, then reloads on each level change.
  - It must not wrap for D = 2^DWELL_W - 1 (terminal compare, no overflow).
- Sweep duration: total busy cycles = D × (number of levels). Number of levels = ceil(NUM_MODULES/S) + 1.

Test Plan:
- Basic ramp: start with S=8, D=4 at cycle 0. Required response:
  - Cycles 1-4: level 0, pwr_en_out=0x00000000.
  - Cycles 5-8: level 8, 0x000000FF.
  - Cycles 9-12: level 16, 0x0000FFFF.
  - Cycles 13-16: level 24, 0x00FFFFFF.
  - Cycles 17-20: level 32, 0xFFFFFFFF.
  - Cycle 21: done=1, busy=0, pwr_en_out=0.
  - level_strobe high only on cycles 1, 5, 9, 13, 17.
- Clamp: S=5, D=2. Required levels 0,5,10,15,20,25,30,32 at 2 cycles each (16 busy cycles), then done. No second level-32 hold.
- Degenerate config: S=0, D=0 behave as S=1, D=1. Required: 33 levels of 1 cycle each, level incrementing every cycle, done 34 cycles after start.
- Abort: S=8, D=4, abort at cycle 10. Required: cycle 11 has pwr_en_out=0, busy=0, done never asserts. A later start runs a full sweep.
- Collisions:
  - start during busy: the sweep is unchanged.
  - abort on the final dwell cycle (cycle 20 in the basic ramp): no done.
  - start on the done cycle: a new sweep begins on the next cycle.
- Reset: rst at cycle 7 of the basic ramp. Required: cycle 8 has all outputs 0 and state IDLE. Config inputs changed mid-sweep have no effect on level spacing.
